// File: rtl/comp_sar_pkg.sv
// rtl/comp_sar_pkg.sv - shared types and midpoint helper for the SAR searcher
package comp_sar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  // Midpoint of an inclusive range [l, h]; callers guarantee l <= h so the
  // subtraction never wraps and the sum never exceeds h.
  function automatic logic [31:0] mid_point(input logic [31:0] l, input logic [31:0] h);
    return l + ((h - l) >> 1);
  endfunction

endpackage

// File: rtl/comp_sar.sv
// rtl/comp_sar.sv - successive-approximation searcher driving an external comparator
module comp_sar
  import comp_sar_pkg::*;
#(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  range_lo,
  input  logic [W-1:0]  range_hi,
  input  logic          cmp_gt,
  input  logic          cmp_lt,
  input  logic          cmp_eq,
  output logic [W-1:0]  probe,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          found,
  output logic          err,
  output logic [CW-1:0] iter
);

  state_t       state;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         flags_ok;

  // Comparator flags are trusted only when exactly one is asserted.
  always_comb begin
    flags_ok = $onehot({cmp_gt, cmp_lt, cmp_eq});
  end

  // Search FSM: latches the range on start, then narrows [lo, hi] one probe per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      result <= '0;
      iter   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            found <= 1'b0;
            err   <= 1'b0;
            iter  <= '0;
            if (range_lo > range_hi) begin
              // Empty range: report not-found immediately, no probe issued.
              done <= 1'b1;
            end else begin
              lo    <= range_lo;
              hi    <= range_hi;
              probe <= W'(mid_point(32'(range_lo), 32'(range_hi)));
              busy  <= 1'b1;
              state <= EVAL;
            end
          end
        end

        EVAL: begin
          iter <= iter + CW'(1);
          if (!flags_ok) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cmp_eq) begin
            result <= probe;
            found  <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (cmp_gt) begin
            // Guard on probe==hi keeps probe+1 from wrapping past the top.
            if (probe == hi) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              lo    <= probe + W'(1);
              probe <= W'(mid_point(32'(probe + W'(1)), 32'(hi)));
            end
          end else begin
            // Guard on probe==lo keeps probe-1 from wrapping below zero.
            if (probe == lo) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              hi    <= probe - W'(1);
              probe <= W'(mid_point(32'(lo), 32'(probe - W'(1))));
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_sar.sv
// tb/tb_comp_sar.sv - self-checking bench for comp_sar against a binary-search model
module tb_comp_sar;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  range_lo;
  logic [W-1:0]  range_hi;
  logic          cmp_gt;
  logic          cmp_lt;
  logic          cmp_eq;
  logic [W-1:0]  probe;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          found;
  logic          err;
  logic [CW-1:0] iter;

  int       a_val;
  bit       ovr_en;
  logic [2:0] ovr;
  int       ncmp = 0;
  int       nfail = 0;
  int       exp_result = 0;

  // Behavioural comparator holding the hidden operand A, with a flag override.
  assign cmp_gt = ovr_en ? ovr[2] : (a_val > int'(probe));
  assign cmp_lt = ovr_en ? ovr[1] : (a_val < int'(probe));
  assign cmp_eq = ovr_en ? ovr[0] : (a_val == int'(probe));

  always #5 clk = ~clk;

  comp_sar #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .range_lo (range_lo),
    .range_hi (range_hi),
    .cmp_gt   (cmp_gt),
    .cmp_lt   (cmp_lt),
    .cmp_eq   (cmp_eq),
    .probe    (probe),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .found    (found),
    .err      (err),
    .iter     (iter)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain binary search over integers, recording each guess.
  task automatic model(input int lo, input int hi, input int a, output int q[$], output bit f);
    int l;
    int h;
    int p;
    q = {};
    f = 1'b0;
    l = lo;
    h = hi;
    while (1) begin
      p = l + (h - l) / 2;
      q.push_back(p);
      if (p == a) begin
        f = 1'b1;
        break;
      end
      if (a > p) begin
        if (p == h) break;
        l = p + 1;
      end else begin
        if (p == l) break;
        h = p - 1;
      end
    end
  endtask

  // Caller is at a negedge. Runs one search and checks probes, latency and status.
  task automatic run_search(input int lo, input int hi, input int a,
                            input bit poke, input bit chain, input string tag);
    int exp_q[$];
    int obs[$];
    bit exp_f;
    bit got;
    int cyc;
    model(lo, hi, a, exp_q, exp_f);
    a_val    = a;
    range_lo = W'(lo);
    range_hi = W'(hi);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    range_lo = W'($urandom);
    range_hi = W'($urandom);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) obs.push_back(int'(probe));
        start = (poke && obs.size() == 1 && exp_q.size() >= 3);
        if (start) begin
          range_lo = 8'd200;
          range_hi = 8'd210;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(exp_q.size()));
    check({tag, ".n_probes"}, 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check($sformatf("%s.probe%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
    if (exp_f) exp_result = a;
    check({tag, ".found"}, 32'(found), 32'(exp_f));
    check({tag, ".result"}, 32'(result), 32'(exp_result));
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".iter"}, 32'(iter), 32'(exp_q.size()));
    check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    if (!chain) begin
      @(negedge clk);
      check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [2:0] bad_flags [2];
    int lo;
    int hi;
    bad_flags[0] = 3'b000;
    bad_flags[1] = 3'b110;

    rst = 1'b1;
    start = 1'b0;
    range_lo = '0;
    range_hi = '0;
    a_val = 0;
    ovr_en = 1'b0;
    ovr = 3'b000;
    repeat (2) @(negedge clk);
    check("reset.probe", 32'(probe), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.iter", 32'(iter), 32'd0);
    check("reset.status", {28'd0, busy, done, found, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_search(0, 3, 2, 1'b0, 1'b0, "r0_3_a2");
    run_search(0, 3, 3, 1'b0, 1'b0, "r0_3_a3");
    run_search(0, 255, 0, 1'b0, 1'b0, "r0_255_a0");
    run_search(10, 20, 25, 1'b0, 1'b0, "r10_20_a25");
    run_search(10, 20, 5, 1'b0, 1'b0, "r10_20_a5");
    run_search(0, 255, 255, 1'b0, 1'b0, "worst_case");
    run_search(0, 255, 0, 1'b1, 1'b0, "start_while_busy");
    run_search(0, 255, 77, 1'b0, 1'b1, "chain_first");
    run_search(100, 120, 110, 1'b0, 1'b0, "chain_second");

    // Non-one-hot flags on the first probe.
    for (int k = 0; k < 2; k++) begin
      ovr_en = 1'b1;
      ovr = bad_flags[k];
      range_lo = 8'd0;
      range_hi = 8'd255;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err.busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("err.done", 32'(done), 32'd1);
      check("err.err", 32'(err), 32'd1);
      check("err.found", 32'(found), 32'd0);
      check("err.iter", 32'(iter), 32'd1);
      check("err.result", 32'(result), 32'(exp_result));
      ovr_en = 1'b0;
      @(negedge clk);
      check("err.done_one_cycle", 32'(done), 32'd0);
    end

    // Empty range: immediate done, not found, no probes.
    range_lo = 8'd5;
    range_hi = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("empty.done", 32'(done), 32'd1);
    check("empty.busy", 32'(busy), 32'd0);
    check("empty.found", 32'(found), 32'd0);
    check("empty.err", 32'(err), 32'd0);
    check("empty.iter", 32'(iter), 32'd0);
    check("empty.result", 32'(result), 32'(exp_result));
    @(negedge clk);
    check("empty.done_one_cycle", 32'(done), 32'd0);

    // Randomized searches, including targets outside the range.
    for (int n = 0; n < 24; n++) begin
      lo = int'($urandom_range(0, 255));
      hi = int'($urandom_range(lo, 255));
      run_search(lo, hi, int'($urandom_range(0, 255)), 1'b0, 1'b0, $sformatf("rand%0d", n));
    end

    // Reset during the second EVAL cycle.
    a_val = 0;
    range_lo = 8'd0;
    range_hi = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_mid.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.probe", 32'(probe), 32'd0);
    check("rst_mid.done", 32'(done), 32'd0);
    check("rst_mid.result", 32'(result), 32'd0);
    check("rst_mid.iter", 32'(iter), 32'd0);
    rst = 1'b0;
    exp_result = 0;
    @(negedge clk);
    check("rst_mid.no_done", 32'(done), 32'd0);
    check("rst_mid.idle", 32'(busy), 32'd0);

    run_search(30, 40, 33, 1'b0, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
